// File: rtl/move_scheduler_if.sv
// Handshake and event bundle between the move scheduler and the game datapath around it.
// master is the scheduler side; slave is the checker/spawner/input side.
interface move_scheduler_if;
    logic       run;
    logic       tick_gravity;
    logic       mv_left;
    logic       mv_right;
    logic       mv_rot;
    logic       mv_hard;
    logic       chk_req;
    logic [1:0] chk_op;
    logic       chk_ack;
    logic       chk_ok;
    logic       commit;
    logic [1:0] commit_op;
    logic       lock_piece;
    logic       spawn_req;
    logic       spawn_ack;
    logic       spawn_ok;
    logic       game_over;
    logic       busy;

    modport master (
        input  run, tick_gravity, mv_left, mv_right, mv_rot, mv_hard,
        input  chk_ack, chk_ok, spawn_ack, spawn_ok,
        output chk_req, chk_op, commit, commit_op, lock_piece, spawn_req, game_over, busy
    );

    modport slave (
        output run, tick_gravity, mv_left, mv_right, mv_rot, mv_hard,
        output chk_ack, chk_ok, spawn_ack, spawn_ok,
        input  chk_req, chk_op, commit, commit_op, lock_piece, spawn_req, game_over, busy
    );
endinterface

// File: rtl/move_scheduler.sv
// Serialises user moves and gravity into collision-check / commit / lock / spawn transactions.
// Pending events are coalesced into one flag per kind and dispatched by fixed priority.
module move_scheduler #(
    parameter int unsigned LOCK_DELAY = 2
) (
    input logic              CLOCK_50,
    input logic              resetn,
    move_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StCommit,
        StLock,
        StSpawn,
        StOver
    } state_e;

    localparam logic [1:0] OpLeft  = 2'd0;
    localparam logic [1:0] OpRight = 2'd1;
    localparam logic [1:0] OpRot   = 2'd2;
    localparam logic [1:0] OpDown  = 2'd3;

    localparam int unsigned FlDown  = 0;
    localparam int unsigned FlRight = 1;
    localparam int unsigned FlLeft  = 2;
    localparam int unsigned FlRot   = 3;
    localparam int unsigned FlHard  = 4;

    localparam logic [3:0] LockDelay = 4'(LOCK_DELAY);

    state_e     state_q;
    logic [4:0] flags_q;
    logic [4:0] flags_d;
    logic [3:0] rest_q;
    logic       hard_q;
    logic       chk_req_q;
    logic [1:0] chk_op_q;
    logic       commit_q;
    logic [1:0] commit_op_q;
    logic       lock_q;
    logic       spawn_req_q;
    logic       game_over_q;
    logic       busy_q;

    logic [4:0] flag_set;
    logic [4:0] flag_clr;
    logic [4:0] sel_clr;
    logic [1:0] sel_op;
    logic       sel_hard;
    logic [3:0] rest_inc;

    // Event capture, priority select and flag next-state.
    always_comb begin
        flag_set = {bus.mv_hard, bus.mv_rot, bus.mv_left, bus.mv_right, bus.tick_gravity}
                   & {5{bus.run}};
        if (state_q == StOver) begin
            flag_set = '0;
        end

        sel_op   = OpDown;
        sel_clr  = '0;
        sel_hard = 1'b0;
        if (flags_q[FlHard]) begin
            sel_clr[FlHard] = 1'b1;
            sel_clr[FlDown] = 1'b1;
            sel_hard        = 1'b1;
        end else if (flags_q[FlRot]) begin
            sel_op         = OpRot;
            sel_clr[FlRot] = 1'b1;
        end else if (flags_q[FlLeft]) begin
            sel_op          = OpLeft;
            sel_clr[FlLeft] = 1'b1;
        end else if (flags_q[FlRight]) begin
            sel_op           = OpRight;
            sel_clr[FlRight] = 1'b1;
        end else begin
            sel_clr[FlDown] = flags_q[FlDown];
        end

        flag_clr = '0;
        if (state_q == StIdle) begin
            flag_clr = sel_clr;
        end

        // A fresh event on the same edge as its dispatch clear survives.
        flags_d = (flags_q & ~flag_clr) | flag_set;
        if (state_q == StLock) begin
            flags_d = '0;
        end

        rest_inc = rest_q + 4'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            flags_q     <= '0;
            rest_q      <= '0;
            hard_q      <= 1'b0;
            chk_req_q   <= 1'b0;
            chk_op_q    <= OpLeft;
            commit_q    <= 1'b0;
            commit_op_q <= OpLeft;
            lock_q      <= 1'b0;
            spawn_req_q <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            commit_q <= 1'b0;
            lock_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|flags_q) begin
                        state_q   <= StCheck;
                        chk_req_q <= 1'b1;
                        chk_op_q  <= sel_op;
                        busy_q    <= 1'b1;
                        if (sel_hard) begin
                            hard_q <= 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (bus.chk_ack) begin
                        chk_req_q <= 1'b0;
                        if (bus.chk_ok) begin
                            state_q     <= StCommit;
                            commit_q    <= 1'b1;
                            commit_op_q <= chk_op_q;
                            if (chk_op_q == OpDown) begin
                                rest_q <= '0;
                            end
                        end else if (chk_op_q != OpDown) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            if (!hard_q) begin
                                rest_q <= rest_inc;
                            end
                            if (hard_q || (rest_inc == LockDelay)) begin
                                state_q <= StLock;
                                lock_q  <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                StCommit: begin
                    if (hard_q) begin
                        state_q   <= StCheck;
                        chk_req_q <= 1'b1;
                        chk_op_q  <= OpDown;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StLock: begin
                    rest_q      <= '0;
                    hard_q      <= 1'b0;
                    state_q     <= StSpawn;
                    spawn_req_q <= 1'b1;
                end
                StSpawn: begin
                    if (bus.spawn_ack) begin
                        spawn_req_q <= 1'b0;
                        if (bus.spawn_ok) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= StOver;
                            game_over_q <= 1'b1;
                        end
                    end
                end
                StOver: begin
                    state_q <= StOver;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.chk_req    = chk_req_q;
    assign bus.chk_op     = chk_op_q;
    assign bus.commit     = commit_q;
    assign bus.commit_op  = commit_op_q;
    assign bus.lock_piece = lock_q;
    assign bus.spawn_req  = spawn_req_q;
    assign bus.game_over  = game_over_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: dispatch priority, coalescing, lock delay, hard drop,
// game over and asynchronous reset behaviour, with hand-computed expectations.
module tb_move_scheduler;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   commits = 0;
    int   locks = 0;
    int   req_rises = 0;
    logic req_prev = 1'b0;
    int   c0;
    int   l0;
    int   r0;

    move_scheduler_if bus();

    move_scheduler #(.LOCK_DELAY(2)) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.commit === 1'b1) commits++;
        if (bus.lock_piece === 1'b1) locks++;
        if (bus.chk_req === 1'b1 && req_prev !== 1'b1) req_rises++;
        req_prev = bus.chk_req;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {6'd0, bus.chk_req, bus.chk_op, bus.commit, bus.commit_op, bus.lock_piece,
                bus.spawn_req, bus.game_over, bus.busy};
    endfunction

    function automatic logic [15:0] over_vec();
        return {10'd0, bus.chk_req, bus.commit, bus.lock_piece, bus.spawn_req,
                bus.game_over, bus.busy};
    endfunction

    task automatic ack_chk(input logic ok);
        bus.chk_ack = 1'b1;
        bus.chk_ok  = ok;
        step();
        bus.chk_ack = 1'b0;
        bus.chk_ok  = 1'b0;
    endtask

    initial begin
        bus.run = 1'b1;
        bus.tick_gravity = 1'b0;
        bus.mv_left = 1'b0;
        bus.mv_right = 1'b0;
        bus.mv_rot = 1'b0;
        bus.mv_hard = 1'b0;
        bus.chk_ack = 1'b0;
        bus.chk_ok = 1'b0;
        bus.spawn_ack = 1'b0;
        bus.spawn_ok = 1'b0;
        resetn = 1'b1;
        #5 resetn = 1'b0;
        step(2);
        check("reset_outputs", outs(), 16'h0000);
        resetn = 1'b1;
        step();

        // Left and gravity together: left first, then down; two commits.
        c0 = commits;
        bus.mv_left = 1'b1;
        bus.tick_gravity = 1'b1;
        step();
        bus.mv_left = 1'b0;
        bus.tick_gravity = 1'b0;
        check("t1_busy_capture", {15'd0, bus.busy}, 16'd0);
        step();
        check("t1_req_left", {15'd0, bus.chk_req}, 16'd1);
        check("t1_op_left", {14'd0, bus.chk_op}, 16'd0);
        step(2);
        check("t1_op_stable", {13'd0, bus.chk_req, bus.chk_op}, 16'h4);
        ack_chk(1'b1);
        check("t1_commit_left", {13'd0, bus.commit, bus.commit_op}, 16'h4);
        check("t1_req_drop", {15'd0, bus.chk_req}, 16'd0);
        step();
        check("t1_commit_single", {15'd0, bus.commit}, 16'd0);
        step();
        check("t1_op_down", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        step(2);
        ack_chk(1'b1);
        check("t1_commit_down", {13'd0, bus.commit, bus.commit_op}, 16'h7);
        step();
        check("t1_two_commits", 16'(commits - c0), 16'd2);

        // Lock delay 2: first failed drop tolerated, second locks; tick during spawn pends.
        bus.tick_gravity = 1'b1;
        step();
        bus.tick_gravity = 1'b0;
        step();
        check("t2_down1", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        ack_chk(1'b0);
        check("t2_no_lock", {14'd0, bus.lock_piece, bus.busy}, 16'd0);
        bus.tick_gravity = 1'b1;
        step();
        bus.tick_gravity = 1'b0;
        step();
        check("t2_down2", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        ack_chk(1'b0);
        check("t2_lock", {14'd0, bus.lock_piece, bus.busy}, 16'h3);
        step();
        check("t2_spawn_req", {14'd0, bus.lock_piece, bus.spawn_req}, 16'h1);
        bus.tick_gravity = 1'b1;
        step();
        bus.tick_gravity = 1'b0;
        check("t2_spawn_hold", {14'd0, bus.chk_req, bus.spawn_req}, 16'h1);
        bus.spawn_ack = 1'b1;
        bus.spawn_ok = 1'b1;
        step();
        bus.spawn_ack = 1'b0;
        bus.spawn_ok = 1'b0;
        check("t2_spawn_done", {14'd0, bus.spawn_req, bus.busy}, 16'd0);
        step();
        check("t2_pending_tick", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        ack_chk(1'b1);
        step();

        // Three ticks while in CHECK coalesce into a single further DOWN.
        r0 = req_rises;
        bus.tick_gravity = 1'b1;
        step();
        bus.tick_gravity = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.tick_gravity = 1'b1;
            step();
            bus.tick_gravity = 1'b0;
            step();
        end
        ack_chk(1'b1);
        step(2);
        check("t3_second_down", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        ack_chk(1'b1);
        step(3);
        check("t3_quiet", {14'd0, bus.chk_req, bus.busy}, 16'd0);
        check("t3_dispatches", 16'(req_rises - r0), 16'd2);

        // Hard drop: four successful DOWNs then a failure locks.
        c0 = commits;
        l0 = locks;
        bus.mv_hard = 1'b1;
        step();
        bus.mv_hard = 1'b0;
        step();
        check("t4_first_down", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        for (int i = 0; i < 4; i++) begin
            ack_chk(1'b1);
            check("t4_commit", {13'd0, bus.commit, bus.commit_op}, 16'h7);
            step();
            check("t4_redrop", {13'd0, bus.chk_req, bus.chk_op}, 16'h7);
        end
        ack_chk(1'b0);
        check("t4_lock", {15'd0, bus.lock_piece}, 16'd1);
        step();
        check("t4_spawn_req", {15'd0, bus.spawn_req}, 16'd1);
        check("t4_commits", 16'(commits - c0), 16'd4);
        check("t4_locks", 16'(locks - l0), 16'd1);
        bus.spawn_ack = 1'b1;
        bus.spawn_ok = 1'b1;
        step();
        bus.spawn_ack = 1'b0;
        bus.spawn_ok = 1'b0;
        step();
        check("t4_idle_after", {14'd0, bus.chk_req, bus.busy}, 16'd0);

        // Priority (rot over right), failed rotation, and a re-pulse surviving its dispatch.
        bus.mv_rot = 1'b1;
        bus.mv_right = 1'b1;
        step();
        bus.mv_rot = 1'b0;
        bus.mv_right = 1'b0;
        step();
        check("t5_rot_first", {13'd0, bus.chk_req, bus.chk_op}, 16'h6);
        ack_chk(1'b0);
        check("t5_rot_fail", {14'd0, bus.commit, bus.busy}, 16'd0);
        bus.mv_right = 1'b1;
        step();
        bus.mv_right = 1'b0;
        check("t5_right", {13'd0, bus.chk_req, bus.chk_op}, 16'h5);
        ack_chk(1'b1);
        check("t5_commit_right", {13'd0, bus.commit, bus.commit_op}, 16'h5);
        step(2);
        check("t5_right_again", {13'd0, bus.chk_req, bus.chk_op}, 16'h5);
        ack_chk(1'b1);
        step(3);
        check("t5_drained", {14'd0, bus.chk_req, bus.busy}, 16'd0);

        // run=0 suppresses capture.
        bus.run = 1'b0;
        bus.mv_left = 1'b1;
        step();
        bus.mv_left = 1'b0;
        step(2);
        check("t6_run_low", {14'd0, bus.chk_req, bus.busy}, 16'd0);
        bus.run = 1'b1;

        // Spawn failure -> game over, inputs ignored until reset.
        bus.mv_hard = 1'b1;
        step();
        bus.mv_hard = 1'b0;
        step();
        ack_chk(1'b0);
        step();
        bus.spawn_ack = 1'b1;
        bus.spawn_ok = 1'b0;
        step();
        bus.spawn_ack = 1'b0;
        check("t7_over", over_vec(), 16'h0003);
        bus.mv_left = 1'b1;
        bus.tick_gravity = 1'b1;
        bus.chk_ack = 1'b1;
        bus.chk_ok = 1'b1;
        bus.spawn_ack = 1'b1;
        bus.spawn_ok = 1'b1;
        step(3);
        bus.mv_left = 1'b0;
        bus.tick_gravity = 1'b0;
        bus.chk_ack = 1'b0;
        bus.chk_ok = 1'b0;
        bus.spawn_ack = 1'b0;
        bus.spawn_ok = 1'b0;
        step(2);
        check("t7_over_sticky", over_vec(), 16'h0003);
        resetn = 1'b0;
        #2;
        check("t7_async_reset", outs(), 16'h0000);
        step();
        resetn = 1'b1;
        step();
        check("t7_after_reset", outs(), 16'h0000);

        // Reset mid-handshake abandons it; a late ack is ignored.
        bus.mv_rot = 1'b1;
        step();
        bus.mv_rot = 1'b0;
        step();
        check("t8_rot_req", {13'd0, bus.chk_req, bus.chk_op}, 16'h6);
        resetn = 1'b0;
        #2;
        check("t8_req_drop", {15'd0, bus.chk_req}, 16'd0);
        step();
        resetn = 1'b1;
        step();
        c0 = commits;
        ack_chk(1'b1);
        check("t8_no_commit", {14'd0, bus.commit, bus.busy}, 16'd0);
        step();
        check("t8_commit_count", 16'(commits - c0), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
